ring_freq_meter: RTL and testbench

RING_FREQ_METER -- requirements
Module: ring_freq_meter

---
 rtl/ring_pkg.sv | 18 +
 rtl/ring_sync_edge.sv | 29 ++
 rtl/ring_freq_meter.sv | 123 ++++++++++++
 tb/tb_ring_freq_meter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and default sizes for the ring-oscillator frequency meter.
package ring_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int GATE_W_DEF   = 16;
  localparam int FLUSH_CYCLES = 2;

  // Flush counter is one bit wide; this is the value it holds in the last flush cycle.
  localparam logic FLUSH_LAST = 1'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    COUNT,
    DONE
  } meterStateT;

endpackage

// File: rtl/ring_sync_edge.sv
// Two-flop synchronizer for the free-running ring output plus a rising-edge detector.
module ring_sync_edge
  import ring_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic asyncIn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic syncPrev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      sync1    <= asyncIn;
      sync2    <= sync1;
      syncPrev <= sync2;
    end
  end

  assign pulse = sync2 & ~syncPrev;

endmodule

// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts ring_in rising edges over a gate window of clk cycles.
// Define RING_FREQ_SAT_EN to saturate the edge counter and flag overflow; otherwise it wraps.
module ring_freq_meter
  import ring_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ring_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              ovf
);

  meterStateT        state;
  meterStateT        stateNext;
  logic              edgePulse;
  logic              accept;
  logic              flushCnt;
  logic [GATE_W-1:0] gateRem;
  logic              lastGate;

  ring_sync_edge uSyncEdge (
    .clk     (clk),
    .rst_n   (rst_n),
    .asyncIn (ring_in),
    .pulse   (edgePulse)
  );

  assign lastGate = (gateRem == GATE_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (flushCnt == FLUSH_LAST) begin
          stateNext = COUNT;
        end
      end
      COUNT: begin
        busy = 1'b1;
        if (lastGate) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A zero gate length still measures for one cycle so the FSM always leaves COUNT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gateRem  <= '0;
      flushCnt <= 1'b0;
      count    <= '0;
      valid    <= 1'b0;
    end else if (accept) begin
      gateRem  <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      flushCnt <= 1'b0;
      count    <= '0;
      valid    <= 1'b0;
    end else if (state == FLUSH) begin
      flushCnt <= flushCnt + 1'b1;
    end else if (state == COUNT) begin
      gateRem <= gateRem - GATE_W'(1);
      if (lastGate) begin
        valid <= 1'b1;
      end
`ifdef RING_FREQ_SAT_EN
      if (edgePulse && !(&count)) begin
        count <= count + CNT_W'(1);
      end
`else
      count <= count + CNT_W'(edgePulse);
`endif
    end
  end

`ifdef RING_FREQ_SAT_EN
  // Overflow means at least one edge arrived after the counter had already pinned at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (state == COUNT && edgePulse && (&count)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: a default-width meter and a 4-bit-count meter share one ring source.
module tb_ring_freq_meter;

  localparam int SMALL_W = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ring_in  = 1'b0;
  logic        start0   = 1'b0;
  logic        start1   = 1'b0;
  logic [15:0] gate_len = '0;

  logic               busy0, done0, valid0, ovf0;
  logic [15:0]        count0;
  logic               busy1, done1, valid1, ovf1;
  logic [SMALL_W-1:0] count1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    int     dut;
    longint cnt;
    logic   ovf;
    int     lat;
  } expT;

  expT   sbQ[$];
  string tagQ[$];

  int ringPeriod = 0;
  int ringPhase  = 0;
  bit ringLevel  = 1'b0;

  ring_freq_meter uDut0 (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start0), .gate_len(gate_len),
    .busy(busy0), .done(done0), .count(count0), .valid(valid0), .ovf(ovf0)
  );

  ring_freq_meter #(.CNT_W(SMALL_W), .GATE_W(16)) uDut1 (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .start(start1), .gate_len(gate_len),
    .busy(busy1), .done(done1), .count(count1), .valid(valid1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // Ring source changes on the falling edge so it never races the meter's sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ringPeriod > 0) begin
        ringPhase = (ringPhase + 1) % ringPeriod;
        ring_in   = (ringPhase < ringPeriod / 2);
      end else begin
        ring_in = ringLevel;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic getDone(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  function automatic logic getBusy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic getValid(input int d);
    return (d == 0) ? valid0 : valid1;
  endfunction

  function automatic logic getOvf(input int d);
    return (d == 0) ? ovf0 : ovf1;
  endfunction

  function automatic longint getCount(input int d);
    return (d == 0) ? longint'(count0) : longint'(count1);
  endfunction

  // Reference behaviour of the counter for a given number of edges in the window.
  function automatic void modelCount(input int edges, input int w, output longint cnt, output logic ov);
    longint maxV;
    maxV = (longint'(1) << w) - 1;
`ifdef RING_FREQ_SAT_EN
    cnt = (edges > maxV) ? maxV : longint'(edges);
    ov  = (edges > maxV);
`else
    cnt = longint'(edges) % (maxV + 1);
    ov  = 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic setRing(input int period, input bit level);
    ringPeriod = period;
    ringPhase  = 0;
    ringLevel  = level;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one start to the chosen meter and queue the result it should produce.
  task automatic applyStimulus(input string tag, input int dut, input int gate, input int edges);
    expT    e;
    longint c;
    logic   o;
    int     g;
    g = (gate == 0) ? 1 : gate;
    modelCount(edges, (dut == 0) ? 16 : SMALL_W, c, o);
    e.dut = dut;
    e.cnt = c;
    e.ovf = o;
    e.lat = 3 + g;
    sbQ.push_back(e);
    tagQ.push_back(tag);
    gate_len = 16'(gate);
    if (dut == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clk);
    #1;
    start0   = 1'b0;
    start1   = 1'b0;
    gate_len = 16'($urandom_range(1, 7));
    checkOutput({tag, ".busy_rise"}, longint'(getBusy(dut)), 1);
    checkOutput({tag, ".valid_clr"}, longint'(getValid(dut)), 0);
  endtask

  // Wait for done, optionally poking start or raising the ring at given cycles, then score.
  task automatic waitDone(input int pokeA, input int pokeB, input int pokeRing);
    expT   e;
    string tag;
    int    lat;
    int    budget;
    bit    seen;
    int    d;
    e      = sbQ[0];
    d      = e.dut;
    lat    = 1;
    seen   = 1'b0;
    budget = e.lat + 10;
    while (!seen && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
      start0 = 1'b0;
      start1 = 1'b0;
      if (lat == pokeA || lat == pokeB) begin
        start0 = (d == 0);
        start1 = (d == 1);
      end
      if (lat == pokeRing) ringLevel = 1'b1;
      if (getDone(d)) seen = 1'b1;
    end
    e   = sbQ.pop_front();
    tag = tagQ.pop_front();
    if (!seen) begin
      start0 = 1'b0;
      start1 = 1'b0;
      checkOutput({tag, ".done_timeout"}, lat, e.lat);
      return;
    end
    checkOutput({tag, ".latency"}, lat, e.lat);
    checkOutput({tag, ".count"}, getCount(d), e.cnt);
    checkOutput({tag, ".ovf"}, longint'(getOvf(d)), longint'(e.ovf));
    checkOutput({tag, ".valid"}, longint'(getValid(d)), 1);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    checkOutput({tag, ".done_pulse"}, longint'(getDone(d)), 0);
    checkOutput({tag, ".busy_fall"}, longint'(getBusy(d)), 0);
    checkOutput({tag, ".count_hold"}, getCount(d), e.cnt);
    checkOutput({tag, ".valid_hold"}, longint'(getValid(d)), 1);
  endtask

  initial begin
    int nDone;
    $display("[TB] ring_freq_meter bench start");

    rst_n = 1'b0;
    settle(3);
    checkOutput("rst.busy0", busy0, 0);
    checkOutput("rst.done0", done0, 0);
    checkOutput("rst.valid0", valid0, 0);
    checkOutput("rst.ovf0", ovf0, 0);
    checkOutput("rst.count0", count0, 0);
    checkOutput("rst.count1", count1, 0);
    checkOutput("rst.valid1", valid1, 0);
    rst_n = 1'b1;
    settle(2);

    setRing(10, 1'b0);
    applyStimulus("p10g100", 0, 100, 10);
    waitDone(0, 0, 0);

    setRing(0, 1'b0);
    settle(4);
    applyStimulus("gate0", 0, 0, 0);
    waitDone(0, 0, 0);

    // Ring rises together with start; only the flushed synchronizer edge exists.
    settle(4);
    ringLevel = 1'b1;
    applyStimulus("stale", 0, 20, 0);
    waitDone(0, 0, 0);

    setRing(0, 1'b0);
    settle(4);
    applyStimulus("lastIn", 0, 8, 1);
    waitDone(0, 0, 8);

    setRing(0, 1'b0);
    settle(4);
    applyStimulus("lastOut", 0, 8, 0);
    waitDone(0, 0, 9);

    setRing(10, 1'b0);
    settle(4);
    applyStimulus("ignore", 0, 100, 10);
    waitDone(60, 103, 0);
    nDone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done0) nDone++;
    end
    checkOutput("ignore.extra_done", nDone, 0);
    checkOutput("ignore.idle_busy", busy0, 0);

    // Abort a measurement with a one-cycle reset in the middle of COUNT.
    gate_len = 16'd100;
    start0   = 1'b1;
    settle(1);
    start0 = 1'b0;
    settle(30);
    checkOutput("abort.busy_before", busy0, 1);
    rst_n = 1'b0;
    settle(1);
    rst_n = 1'b1;
    checkOutput("abort.busy", busy0, 0);
    checkOutput("abort.done", done0, 0);
    checkOutput("abort.valid", valid0, 0);
    checkOutput("abort.ovf", ovf0, 0);
    checkOutput("abort.count", count0, 0);
    settle(1);
    checkOutput("abort.idle", busy0, 0);
    applyStimulus("afterRst", 0, 50, 5);
    waitDone(0, 0, 0);

    setRing(2, 1'b0);
    settle(4);
    applyStimulus("w4g20", 1, 20, 10);
    waitDone(0, 0, 0);
    applyStimulus("w4g30", 1, 30, 15);
    waitDone(0, 0, 0);
    applyStimulus("w4g64", 1, 64, 32);
    waitDone(0, 0, 0);

    settle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
